// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   OP_W / PROD_W : operand and product widths of the external multiplier.
//   rsp_entry_t   : one response FIFO entry {requester id, product}.
//   rr_pick()     : round-robin search returning the first valid index at or after ptr.
package mult_arb_pkg;

   localparam int unsigned OP_W     = 8;
   localparam int unsigned PROD_W   = 16;
   localparam int unsigned MAX_REQ  = 8;
   localparam int unsigned ID_MAX_W = 3;

   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic [PROD_W-1:0]   prod;
   } rsp_entry_t;

   // Search starts at ptr and wraps modulo n_req; returns ptr when nothing is valid.
   function automatic logic [ID_MAX_W-1:0] rr_pick(input logic [MAX_REQ-1:0]  valid,
                                                   input logic [ID_MAX_W-1:0] ptr,
                                                   input int unsigned         n_req);
      int unsigned idx;
      logic        found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int unsigned k = 0; k < MAX_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= n_req) idx = idx - n_req;
         if (k < n_req && !found && valid[idx[ID_MAX_W-1:0]]) begin
            rr_pick = idx[ID_MAX_W-1:0];
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/mult_arb_rsp_fifo.sv
// Response FIFO for the multiplier-sharing arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears contents)
//   push       : write push_data at the tail
//   push_data  : entry to write
//   pop        : drop the head entry (only meaningful while valid)
//   valid      : FIFO is non-empty
//   head       : entry at the head (zero after reset)
//   count      : number of stored entries
// Never overflows: the arbiter only issues while it holds a credit for a free slot.
module mult_arb_rsp_fifo
   import mult_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  rsp_entry_t       push_data,
   input  logic             pop,
   output logic             valid,
   output rsp_entry_t       head,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   rsp_entry_t       mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             full;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign valid = (count_q != '0);
   assign full  = (32'(count_q) == DEPTH);
   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

   no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full))
      else $error("response fifo overflow");

endmodule

// File: rtl/mult_share_arb.sv
// Shares one external 8x8 unsigned multiplier among N_REQ requesters.
// Round-robin grant (one issue per cycle), a tag pipe that carries each requester id
// alongside the multiplier latency, and a credit-protected response FIFO.
// Optional build macro: MULT_ARB_STATS_EN adds stat_issue / stat_stall counters.
// Ports:
//   clk, rst_n          : clock (posedge), asynchronous active-low reset
//   req_valid/req_ready : per-requester handshake; req_ready is the one-hot grant
//   req_a/req_b         : packed operands, requester i at [8i+7:8i]
//   mul_a/mul_b         : registered operands to the multiplier
//   mul_p               : multiplier product, valid MUL_LAT posedges after mul_a/mul_b
//   rsp_valid/rsp_ready : response handshake on the FIFO head
//   rsp_id/rsp_p        : requester id and product of the head
//   stat_issue          : (MULT_ARB_STATS_EN) saturating count of issues
//   stat_stall          : (MULT_ARB_STATS_EN) saturating count of cycles with a request but no issue
module mult_share_arb
   import mult_arb_pkg::*;
#(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned MUL_LAT   = 1,
   parameter int unsigned RSP_DEPTH = 4,
   parameter int unsigned IDW       = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*OP_W-1:0] req_a,
   input  logic [N_REQ*OP_W-1:0] req_b,
   output logic [OP_W-1:0]       mul_a,
   output logic [OP_W-1:0]       mul_b,
   input  logic [PROD_W-1:0]     mul_p,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [PROD_W-1:0]     rsp_p
`ifdef MULT_ARB_STATS_EN
   ,
   output logic [31:0]           stat_issue,
   output logic [31:0]           stat_stall
`endif
);

   localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
   localparam int unsigned N_STG = MUL_LAT + 1;

   logic [IDW-1:0]   ptr_q;
   logic [N_STG-1:0] tag_vld_q;
   logic [IDW-1:0]   tag_id_q [N_STG];

   logic [CNT_W-1:0] fifo_count;
   logic             fifo_valid;
   logic [31:0]      inflight;
   logic             has_credit;
   logic             any_valid;
   logic             issue;
   logic [IDW-1:0]   grant_idx;
   logic             push;
   logic             pop;
   rsp_entry_t       push_entry;
   rsp_entry_t       head_entry;

   always_comb begin
      inflight = '0;
      for (int k = 0; k < N_STG; k++) inflight = inflight + 32'(tag_vld_q[k]);
   end

   // Credits come from registered state only, so a same-cycle pop frees its slot one
   // cycle late; that lag is what keeps a push from ever meeting a full FIFO.
   assign has_credit = (32'(fifo_count) + inflight) < RSP_DEPTH;
   assign any_valid  = |req_valid;
   assign grant_idx  = IDW'(rr_pick(MAX_REQ'(req_valid), ID_MAX_W'(ptr_q), N_REQ));
   assign issue      = any_valid && has_credit;

   always_comb begin
      req_ready = '0;
      if (issue) req_ready[grant_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q     <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         tag_vld_q <= '0;
         for (int k = 0; k < N_STG; k++) tag_id_q[k] <= '0;
      end else begin
         // Tag pipe never stalls: the multiplier has no back-pressure either.
         tag_vld_q   <= {tag_vld_q[N_STG-2:0], issue};
         tag_id_q[0] <= grant_idx;
         for (int k = 1; k < N_STG; k++) tag_id_q[k] <= tag_id_q[k-1];
         if (issue) begin
            mul_a <= req_a[32'(grant_idx)*OP_W +: OP_W];
            mul_b <= req_b[32'(grant_idx)*OP_W +: OP_W];
            ptr_q <= (32'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
         end
      end
   end

   // Last tag stage lines up with a valid mul_p.
   assign push            = tag_vld_q[N_STG-1];
   assign push_entry.id   = ID_MAX_W'(tag_id_q[N_STG-1]);
   assign push_entry.prod = mul_p;
   assign pop             = fifo_valid && rsp_ready;

   mult_arb_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .CNT_W (CNT_W)
   ) u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .valid     (fifo_valid),
      .head      (head_entry),
      .count     (fifo_count)
   );

   assign rsp_valid = fifo_valid;
   assign rsp_id    = IDW'(head_entry.id);
   assign rsp_p     = head_entry.prod;

`ifdef MULT_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_issue <= '0;
         stat_stall <= '0;
      end else begin
         if (issue && stat_issue != '1) stat_issue <= stat_issue + 32'd1;
         if (any_valid && !issue && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mult_share_arb.sv
// Self-checking bench for mult_share_arb: table-driven single requests, hand-written
// fairness / backpressure / reset sequences, and randomized traffic checked by a
// queue-based reference model that runs alongside every phase.
module tb_mult_share_arb;

   localparam int unsigned N_REQ     = 4;
   localparam int unsigned MUL_LAT   = 1;
   localparam int unsigned RSP_DEPTH = 4;
   localparam int unsigned IDW       = 2;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ-1:0]     req_ready;
   logic [N_REQ*8-1:0]   req_a;
   logic [N_REQ*8-1:0]   req_b;
   logic [7:0]           mul_a;
   logic [7:0]           mul_b;
   logic [15:0]          mul_p;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [15:0]          rsp_p;
`ifdef MULT_ARB_STATS_EN
   logic [31:0]          stat_issue;
   logic [31:0]          stat_stall;
`endif

   mult_share_arb #(
      .N_REQ     (N_REQ),
      .MUL_LAT   (MUL_LAT),
      .RSP_DEPTH (RSP_DEPTH),
      .IDW       (IDW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_p      (mul_p),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_p      (rsp_p)
`ifdef MULT_ARB_STATS_EN
      ,
      .stat_issue (stat_issue),
      .stat_stall (stat_stall)
`endif
   );

   always #5 clk = ~clk;

   // External multiplier with one cycle of latency.
   always @(posedge clk) mul_p <= 16'(mul_a) * 16'(mul_b);

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Outstanding work = products still in the multiplier + results waiting in the FIFO.
   // A result becomes visible MUL_LAT+1 edges after its issue edge.
   typedef struct { int id; int p; longint land; } pend_t;
   typedef struct { int id; int p; } rsp_t;

   pend_t  m_pend[$];
   rsp_t   m_fifo[$];
   int     m_ptr   = 0;
   longint m_edge  = 0;
   int     m_a     = 0;
   int     m_b     = 0;
   int     m_issue = 0;
   int     m_stall = 0;

   always @(negedge clk) begin : model
      int               win;
      int               idx;
      int               outst;
      logic [N_REQ-1:0] exp_rdy;
      pend_t            pe;
      rsp_t             re;
      if (!rst_n) begin
         m_pend.delete();
         m_fifo.delete();
         m_ptr   = 0;
         m_a     = 0;
         m_b     = 0;
         m_issue = 0;
         m_stall = 0;
         chk("rst_rsp_valid", 32'(rsp_valid), 0);
         chk("rst_mul_a", 32'(mul_a), 0);
         chk("rst_mul_b", 32'(mul_b), 0);
      end else begin
         outst = m_pend.size() + m_fifo.size();
         win   = -1;
         for (int k = 0; k < N_REQ; k++) begin
            idx = (m_ptr + k) % N_REQ;
            if (win < 0 && req_valid[idx]) win = idx;
         end
         exp_rdy = '0;
         if (win >= 0 && outst < RSP_DEPTH) exp_rdy[win] = 1'b1;
         chk("m_grant", 32'(req_ready), 32'(exp_rdy));
         chk("m_rsp_valid", 32'(rsp_valid), 32'(m_fifo.size() > 0));
         if (m_fifo.size() > 0) begin
            chk("m_rsp_id", 32'(rsp_id), m_fifo[0].id);
            chk("m_rsp_p", 32'(rsp_p), m_fifo[0].p);
         end
         chk("m_mul_a", 32'(mul_a), m_a);
         chk("m_mul_b", 32'(mul_b), m_b);
         // Advance to the coming posedge.
         if (rsp_ready && m_fifo.size() > 0) void'(m_fifo.pop_front());
         while (m_pend.size() > 0 && m_pend[0].land == m_edge) begin
            pe = m_pend.pop_front();
            re.id = pe.id;
            re.p  = pe.p;
            m_fifo.push_back(re);
         end
         if (exp_rdy != '0) begin
            m_a     = int'(req_a[win*8 +: 8]);
            m_b     = int'(req_b[win*8 +: 8]);
            pe.id   = win;
            pe.p    = m_a * m_b;
            pe.land = m_edge + MUL_LAT + 1;
            m_pend.push_back(pe);
            m_ptr   = (win + 1) % N_REQ;
            m_issue++;
         end else if (req_valid != '0) begin
            m_stall++;
         end
         m_edge++;
      end
   end

   // ---------------- stimulus ----------------
   typedef struct { int req; logic [7:0] a; logic [7:0] b; logic [15:0] p; } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One request from v.req into an idle arbiter; checks grant, latency and result.
   task automatic run_vec(input vec_t v);
      int lat;
      lat = 0;
      req_valid = '0;
      req_valid[v.req] = 1'b1;
      req_a[v.req*8 +: 8] = v.a;
      req_b[v.req*8 +: 8] = v.b;
      @(negedge clk);
      chk("vec_grant", 32'(req_ready), 32'(1) << v.req);
      tick();
      req_valid = '0;
      for (int t = 2; t < 12; t++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = t;
            break;
         end
      end
      chk("vec_latency", lat, MUL_LAT + 3);
      chk("vec_id", 32'(rsp_id), v.req);
      chk("vec_p", 32'(rsp_p), 32'(v.p));
      tick();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
      $fatal(1);
   end

   initial begin : main
      vec_t vecs [7];
      int   exp_g;
      int   exp_r;
      int   cnt;

      vecs[0] = '{req: 0, a: 8'd200, b: 8'd150, p: 16'd30000};
      vecs[1] = '{req: 1, a: 8'd255, b: 8'd255, p: 16'd65025};
      vecs[2] = '{req: 2, a: 8'd0,   b: 8'd255, p: 16'd0};
      vecs[3] = '{req: 3, a: 8'd1,   b: 8'd1,   p: 16'd1};
      vecs[4] = '{req: 0, a: 8'd13,  b: 8'd17,  p: 16'd221};
      vecs[5] = '{req: 2, a: 8'd128, b: 8'd2,   p: 16'd256};
      vecs[6] = '{req: 1, a: 8'd255, b: 8'd1,   p: 16'd255};

      rst_n     = 1'b0;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Table-driven single requests.
      rsp_ready = 1'b1;
      foreach (vecs[i]) begin
         repeat (4) tick();
         run_vec(vecs[i]);
      end

      // Fairness: all requesters valid, consumer always ready.
      do_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < N_REQ; i++) begin
         req_a[i*8 +: 8] = 8'(i + 1);
         req_b[i*8 +: 8] = 8'd10;
      end
      req_valid = '1;
      exp_g = 0;
      exp_r = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         chk("fair_grant", 32'(req_ready), 32'(1) << exp_g);
         exp_g = (exp_g + 1) % N_REQ;
         if (rsp_valid) begin
            chk("fair_id", 32'(rsp_id), exp_r);
            chk("fair_p", 32'(rsp_p), (exp_r + 1) * 10);
            exp_r = (exp_r + 1) % N_REQ;
         end
         tick();
      end
      req_valid = '0;
      repeat (6) tick();

      // Backpressure: only RSP_DEPTH issues fit while the consumer stalls.
      rsp_ready = 1'b0;
      req_valid = '1;
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         cnt += $countones(req_ready);
         tick();
      end
      chk("bp_issues", cnt, RSP_DEPTH);
      @(negedge clk);
      chk("bp_blocked", 32'(req_ready), 0);
      tick();
      req_valid = '0;
      rsp_ready = 1'b1;
      cnt = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rsp_valid) cnt++;
         tick();
      end
      chk("bp_drained", cnt, RSP_DEPTH);
      req_valid = 4'b1000;
      @(negedge clk);
      chk("bp_resume", 32'(req_ready), 32'(4'b1000));
      tick();
      req_valid = '0;
      repeat (6) tick();

      // Reset with two products in flight and two results queued.
      rsp_ready  = 1'b0;
      req_valid  = 4'b0001;
      req_a[7:0] = 8'd5;
      req_b[7:0] = 8'd6;
      repeat (3) tick();
      @(negedge clk);
      chk("pre_rst_valid", 32'(rsp_valid), 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      req_valid = '0;
      #1;
      chk("rst_async_valid", 32'(rsp_valid), 0);
      chk("rst_async_mul_a", 32'(mul_a), 0);
      chk("rst_async_mul_b", 32'(mul_b), 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;
      run_vec('{req: 2, a: 8'd7, b: 8'd9, p: 16'd63});

      // Randomized traffic, checked by the reference model.
      for (int c = 0; c < 400; c++) begin
         req_valid = N_REQ'($urandom_range(0, 15));
         req_a     = $urandom;
         req_b     = $urandom;
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (8) tick();

`ifdef MULT_ARB_STATS_EN
      @(negedge clk);
      chk("stat_issue", stat_issue, m_issue);
      chk("stat_stall", stat_stall, m_stall);
`endif

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
